// File: rtl/instruction_encoder_pkg.sv
// Shared format codes, opcode constants and range-check helper for the RV32I encoder.
// Imported by the field packer, the streaming top level and the bench.
package instruction_encoder_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } format_e;

    localparam logic [31:0] ILLEGAL_INSTRUCTION = 32'h0000_0000;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] JAL    = 7'h6F;

    typedef struct packed {
        logic [31:0] instruction;
        logic        error;
    } encoded_t;

    // True when imm[31:lsb] are all copies of the sign bit, i.e. the value
    // fits a signed field whose top bit sits at position lsb.
    function automatic logic sign_run(input logic [31:0] imm, input int lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= lsb && imm[i] != imm[31]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/instruction_encode_fields.sv
// Combinational RV32I field packer with immediate range check.
// Out-of-range immediates and unknown formats yield the illegal all-zero word.
module instruction_encode_fields
    import instruction_encoder_pkg::*;
(
    input  logic [2:0]  format,
    input  logic [6:0]  opcode,
    input  logic [4:0]  source_reg_1,
    input  logic [4:0]  source_reg_2,
    input  logic [4:0]  destination_reg,
    input  logic [2:0]  subfunction_3,
    input  logic [6:0]  subfunction_7,
    input  logic [31:0] immediate,
    output encoded_t    result
);

    logic [31:0] word;
    logic        bad;

    always_comb begin
        word = ILLEGAL_INSTRUCTION;
        bad  = 1'b0;
        case (format)
            FMT_R: begin
                word = {subfunction_7, source_reg_2, source_reg_1, subfunction_3,
                        destination_reg, opcode};
            end
            FMT_I: begin
                word = {immediate[11:0], source_reg_1, subfunction_3, destination_reg, opcode};
                bad  = !sign_run(immediate, 11);
            end
            FMT_S: begin
                word = {immediate[11:5], source_reg_2, source_reg_1, subfunction_3,
                        immediate[4:0], opcode};
                bad  = !sign_run(immediate, 11);
            end
            FMT_B: begin
                word = {immediate[12], immediate[10:5], source_reg_2, source_reg_1,
                        subfunction_3, immediate[4:1], immediate[11], opcode};
                bad  = immediate[0] || !sign_run(immediate, 12);
            end
            FMT_U: begin
                word = {immediate[31:12], destination_reg, opcode};
                bad  = (immediate[11:0] != 12'h000);
            end
            FMT_J: begin
                word = {immediate[20], immediate[10:1], immediate[11], immediate[19:12],
                        destination_reg, opcode};
                bad  = immediate[0] || !sign_run(immediate, 20);
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        result.instruction = bad ? ILLEGAL_INSTRUCTION : word;
        result.error       = bad;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I encoder: one-deep output register with back-pressure,
// sequential instruction-memory address, sticky wrap flag and transfer count.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  format,
    input  logic [6:0]  opcode,
    input  logic [4:0]  source_reg_1,
    input  logic [4:0]  source_reg_2,
    input  logic [4:0]  destination_reg,
    input  logic [2:0]  subfunction_3,
    input  logic [6:0]  subfunction_7,
    input  logic [31:0] immediate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_address,
    output logic        out_error,
    output logic        wrapped,
    output logic [15:0] encoded_count
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));

    encoded_t    encoded;
    logic        accept;
    logic        transfer;
    logic        at_last;
    logic [31:0] next_address;

    instruction_encode_fields u_fields (
        .format          (format),
        .opcode          (opcode),
        .source_reg_1    (source_reg_1),
        .source_reg_2    (source_reg_2),
        .destination_reg (destination_reg),
        .subfunction_3   (subfunction_3),
        .subfunction_7   (subfunction_7),
        .immediate       (immediate),
        .result          (encoded)
    );

    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign transfer     = out_valid && out_ready;
    assign at_last      = (out_address == LAST_ADDR);
    assign next_address = at_last ? BASE_ADDR : out_address + 32'd4;

    // out_address always names the slot of the word held (or the next one to
    // be accepted), so a same-cycle accept+transfer picks up the advanced slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_instruction <= ILLEGAL_INSTRUCTION;
            out_error       <= 1'b0;
            out_address     <= BASE_ADDR;
            wrapped         <= 1'b0;
            encoded_count   <= 16'h0000;
        end else begin
            if (transfer) begin
                out_address <= next_address;
                if (at_last) begin
                    wrapped <= 1'b1;
                end
                if (encoded_count != 16'hFFFF) begin
                    encoded_count <= encoded_count + 16'd1;
                end
            end

            if (accept) begin
                out_valid       <= 1'b1;
                out_instruction <= encoded.instruction;
                out_error       <= encoded.error;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed vectors, errors,
// back-pressure, address wrap, reset mid-transfer and decoder round-trips.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    localparam logic [31:0] TB_BASE  = 32'h0000_0000;
    localparam int          TB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  format;
    logic [6:0]  opcode;
    logic [4:0]  source_reg_1;
    logic [4:0]  source_reg_2;
    logic [4:0]  destination_reg;
    logic [2:0]  subfunction_3;
    logic [6:0]  subfunction_7;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_address;
    logic        out_error;
    logic        wrapped;
    logic [15:0] encoded_count;

    typedef struct {
        logic        round_trip;
        logic [31:0] instr;
        logic        err;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb[$];
    exp_t        pending;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_addr;
    int          exp_count;
    logic        exp_wrapped;
    logic        accepted;

    instruction_encoder #(
        .BASE_ADDR   (TB_BASE),
        .DEPTH_WORDS (TB_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .format          (format),
        .opcode          (opcode),
        .source_reg_1    (source_reg_1),
        .source_reg_2    (source_reg_2),
        .destination_reg (destination_reg),
        .subfunction_3   (subfunction_3),
        .subfunction_7   (subfunction_7),
        .immediate       (immediate),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_address     (out_address),
        .out_error       (out_error),
        .wrapped         (wrapped),
        .encoded_count   (encoded_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Immediate as an RV32I decoder would reconstruct it.
    function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] i);
        case (fmt)
            FMT_I:   return {{20{i[31]}}, i[31:20]};
            FMT_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   return {i[31:12], 12'h000};
            FMT_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    // Tuple of the fields meaningful for a format; unused fields are zeroed.
    function automatic logic [63:0] key_of(input logic [2:0] fmt, input logic [6:0] op,
                                           input logic [4:0] rd, input logic [2:0] f3,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [6:0] f7, input logic [31:0] imm);
        case (fmt)
            FMT_R:        return {op, rd, f3, rs1, rs2, f7, 32'h0};
            FMT_I:        return {op, rd, f3, rs1, 5'h0, 7'h0, imm};
            FMT_S, FMT_B: return {op, 5'h0, f3, rs1, rs2, 7'h0, imm};
            default:      return {op, rd, 3'h0, 5'h0, 5'h0, 7'h0, imm};
        endcase
    endfunction

    task automatic step();
        exp_t        e;
        logic [63:0] got_key;
        logic [63:0] want_key;
        accepted = 1'b0;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got instr=%h, required no word", out_instruction);
            end else begin
                e = sb.pop_front();
                if (out_address !== exp_addr) begin
                    bad++;
                    $display("FAIL address: got %h required %h", out_address, exp_addr);
                end
                total++;
                if (e.round_trip) begin
                    got_key  = key_of(e.fmt, out_instruction[6:0], out_instruction[11:7],
                                      out_instruction[14:12], out_instruction[19:15],
                                      out_instruction[24:20], out_instruction[31:25],
                                      decode_imm(e.fmt, out_instruction));
                    want_key = key_of(e.fmt, e.op, e.rd, e.f3, e.rs1, e.rs2, e.f7, e.imm);
                    if (got_key !== want_key || out_error !== 1'b0) begin
                        bad++;
                        $display("FAIL round_trip fmt=%0d: got word %h err %b, required fields %h err 0",
                                 e.fmt, out_instruction, out_error, want_key);
                    end
                end else if (out_instruction !== e.instr || out_error !== e.err) begin
                    bad++;
                    $display("FAIL word: got %h err %b, required %h err %b",
                             out_instruction, out_error, e.instr, e.err);
                end
                if (exp_addr == TB_BASE + 32'(4 * (TB_DEPTH - 1))) begin
                    exp_addr    = TB_BASE;
                    exp_wrapped = 1'b1;
                end else begin
                    exp_addr = exp_addr + 32'd4;
                end
                exp_count++;
            end
        end
        if (!reset && in_valid && in_ready) begin
            sb.push_back(pending);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] exp_instr, input logic exp_err, input logic rt);
        format = fmt; opcode = op; destination_reg = rd; source_reg_1 = rs1;
        source_reg_2 = rs2; subfunction_3 = f3; subfunction_7 = f7; immediate = imm;
        pending = '{round_trip: rt, instr: exp_instr, err: exp_err, fmt: fmt, op: op, rd: rd,
                    rs1: rs1, rs2: rs2, f3: f3, f7: f7, imm: imm};
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] exp_instr, input logic exp_err, input logic rt);
        int n;
        set_fields(fmt, op, rd, rs1, rs2, f3, f7, imm, exp_instr, exp_err, rt);
        in_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 20);
        in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", sb.size());
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        exp_addr    = TB_BASE;
        exp_count   = 0;
        exp_wrapped = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (out_valid !== 1'b0 || out_instruction !== 32'h0 || out_error !== 1'b0 ||
            out_address !== TB_BASE || wrapped !== 1'b0 || encoded_count !== 16'h0 ||
            in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s: got v=%b i=%h e=%b a=%h w=%b c=%0d r=%b, required v=0 i=0 e=0 a=%h w=0 c=0 r=1",
                     tag, out_valid, out_instruction, out_error, out_address, wrapped,
                     encoded_count, in_ready, TB_BASE);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b1;
        set_fields(FMT_R, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        apply_reset();
        step();
        check_reset_values("reset_state");
    endtask

    task automatic test_i_format();
        apply_reset();
        out_ready = 1'b1;
        drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_instruction !== 32'h0050_0093 || out_address !== TB_BASE) begin
            bad++;
            $display("FAIL i_latency: got v=%b i=%h a=%h, required v=1 i=00500093 a=%h",
                     out_valid, out_instruction, out_address, TB_BASE);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1;
        drive(FMT_S, STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0, 1'b0);
        drive(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 32'hFE00_0EE3, 1'b0, 1'b0);
        drain();
        total++;
        if (out_address !== TB_BASE + 32'd8 || encoded_count !== 16'd2) begin
            bad++;
            $display("FAIL b2b_progress: got a=%h c=%0d, required a=%h c=2",
                     out_address, encoded_count, TB_BASE + 32'd8);
        end
    endtask

    task automatic test_j_u();
        out_ready = 1'b1;
        drive(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0, 1'b0);
        drive(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0, 1'b1, 1'b0);
        drive(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0, 1'b1, 1'b0);
        drive(3'd7, OP_IMM, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0, 1'b1, 1'b0);
        drive(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0, 1'b1, 1'b0);
        drive(FMT_U, LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0, 1'b1, 1'b0);
        drain();
        total++;
        if (out_address !== exp_addr || encoded_count !== 16'(exp_count)) begin
            bad++;
            $display("FAIL error_progress: got a=%h c=%0d, required a=%h c=%0d",
                     out_address, encoded_count, exp_addr, exp_count);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(FMT_I, OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0113, 1'b0, 1'b0);
        set_fields(FMT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0193, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instruction !== 32'h0010_0113 ||
                out_address !== exp_addr || accepted) begin
                bad++;
                $display("FAIL back_pressure cycle %0d: got r=%b v=%b i=%h a=%h acc=%b, required r=0 v=1 i=00100113 a=%h acc=0",
                         k, in_ready, out_valid, out_instruction, out_address, accepted, exp_addr);
            end
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_wrap();
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(FMT_I, OP_IMM, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k),
                  {12'(k), 5'd0, 3'd0, 5'(k + 1), OP_IMM}, 1'b0, 1'b0);
        end
        drain();
        total++;
        if (wrapped !== 1'b0 || out_address !== TB_BASE + 32'd12) begin
            bad++;
            $display("FAIL pre_wrap: got w=%b a=%h, required w=0 a=%h", wrapped, out_address, TB_BASE + 32'd12);
        end
        for (int k = 3; k < 6; k++) begin
            drive(FMT_I, OP_IMM, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k),
                  {12'(k), 5'd0, 3'd0, 5'(k + 1), OP_IMM}, 1'b0, 1'b0);
        end
        drain();
        total++;
        if (wrapped !== 1'b1 || exp_wrapped !== 1'b1 || out_address !== TB_BASE + 32'd8 ||
            encoded_count !== 16'd6) begin
            bad++;
            $display("FAIL post_wrap: got w=%b a=%h c=%0d, required w=1 a=%h c=6",
                     wrapped, out_address, encoded_count, TB_BASE + 32'd8);
        end
    endtask

    task automatic test_reset_midtransfer();
        out_ready = 1'b0;
        drive(FMT_U, LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 32'hABCD_E3B7, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid: got v=%b, required v=1", out_valid);
        end
        apply_reset();
        check_reset_values("reset_midtransfer");
        out_ready = 1'b1;
        drive(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_round_trip();
        logic [31:0] r;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [6:0]  ops [6];
        ops = '{7'h33, OP_IMM, STORE, BRANCH, LUI, JAL};
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r   = $urandom;
            fmt = 3'($urandom_range(0, 5));
            case (fmt)
                FMT_I, FMT_S: imm = {{20{r[11]}}, r[11:0]};
                FMT_B:        imm = {{19{r[12]}}, r[12:1], 1'b0};
                FMT_U:        imm = {r[31:12], 12'h000};
                FMT_J:        imm = {{11{r[20]}}, r[20:1], 1'b0};
                default:      imm = r;
            endcase
            drive(fmt, ops[fmt], 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                  7'($urandom), imm, 32'h0, 1'b0, 1'b1);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_i_format();
        test_back_to_back();
        test_j_u();
        test_errors();
        test_back_pressure();
        test_wrap();
        test_reset_midtransfer();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
